argmax_unit: RTL and testbench

ARGMAX_UNIT -- requirements
Module: argmax_unit

---
 rtl/argmax_unit.sv | 102 ++++++++++
 tb/tb_argmax_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/argmax_unit.sv
// Argmax over one inference's output-layer scores.
// Signed strict-greater compare; ties keep the lowest index.
module argmax_unit #(
    parameter int NO_NOL = 10,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    score_valid,
    input  logic signed [7:0]       score,
    output logic                    busy,
    output logic [IDX_W-1:0]        class_idx,
    output logic signed [7:0]       max_score,
    output logic                    result_valid
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_NOL - 1);
    localparam logic signed [7:0] MIN_SCORE = 8'sh80;

    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0]  cnt;
    logic signed [7:0] run_max;
    logic [IDX_W-1:0]  run_idx;

    logic              accept;
    logic              last;
    logic              take;
    logic signed [7:0] cmp_max;
    logic [IDX_W-1:0]  cmp_idx;

    assign last = (cnt == LAST_IDX);

    // Count zero forces a load so a lone -128 still becomes the max.
    assign take    = (cnt == '0) || (score > run_max);
    assign cmp_max = take ? score : run_max;
    assign cmp_idx = take ? cnt : run_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        accept       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = COLLECT;
            end
            COLLECT: begin
                busy   = 1'b1;
                accept = score_valid;
                if (score_valid && last) state_nx = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            run_max   <= MIN_SCORE;
            run_idx   <= '0;
            class_idx <= '0;
            max_score <= '0;
        end else if (state == IDLE && start) begin
            cnt     <= '0;
            run_max <= MIN_SCORE;
            run_idx <= '0;
        end else if (accept) begin
            run_max <= cmp_max;
            run_idx <= cmp_idx;
            // Publish straight from the final compare; counter parks at the end.
            if (last) begin
                class_idx <= cmp_idx;
                max_score <= cmp_max;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_argmax_unit.sv
// Scoreboard bench for argmax_unit.
// Expected class/score pushed at the last score, popped on result_valid.
module tb_argmax_unit;

    localparam int N     = 10;
    localparam int IDX_W = 4;

    typedef int arr_t[N];
    typedef struct {
        int idx;
        int mx;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              score_valid;
    logic signed [7:0] score;
    logic              busy;
    logic [IDX_W-1:0]  class_idx;
    logic signed [7:0] max_score;
    logic              result_valid;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   nres = 0;
    int   npush = 0;
    int   last_idx = 0;
    int   last_max = 0;
    bit   post_done = 1'b0;
    exp_t sb[$];
    exp_t got_e;

    arr_t basic  = '{3, 7, -2, 40, 5, 0, 12, 39, 1, 8};
    arr_t ties   = '{-5, -5, -1, -1, -128, -128, -128, -128, -128, -128};
    arr_t allmin = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    arr_t r90    = '{10, -3, 50, 89, 0, 89, -100, 20, 7, 90};

    argmax_unit #(.NO_NOL(N), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .score_valid (score_valid),
        .score       (score),
        .busy        (busy),
        .class_idx   (class_idx),
        .max_score   (max_score),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input arr_t s, output int idx, output int mx);
        idx = 0;
        mx  = s[0];
        for (int i = 1; i < N; i++) begin
            if (s[i] > mx) begin
                mx  = s[i];
                idx = i;
            end
        end
    endfunction

    task automatic run(input arr_t s, input int maxgap, input bit inj,
                       input bit in_done);
        exp_t e;
        int   ix;
        int   mx;
        int   g;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            score_valid = 1'b0;
            repeat (g) begin
                start = inj;
                tick();
                start = 1'b0;
            end
            if (i == N - 1) begin
                model(s, ix, mx);
                e.idx = ix;
                e.mx  = mx;
                e.cyc = cyc + 1;
                sb.push_back(e);
                npush++;
            end
            score_valid = 1'b1;
            score       = 8'(s[i]);
            tick();
        end
        score_valid = in_done;
        score       = 8'sd127;
        tick();
        score_valid = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            last_idx  = 0;
            last_max  = 0;
            post_done = 1'b0;
        end else begin
            if (post_done) begin
                chk("busy_after", int'(busy), 0);
                post_done = 1'b0;
            end
            if (result_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rv", 1, 0);
                end else begin
                    got_e = sb.pop_front();
                    chk("class_idx", int'(class_idx), got_e.idx);
                    chk("max_score", int'(max_score), got_e.mx);
                    chk("latency", cyc, got_e.cyc);
                    last_idx = got_e.idx;
                    last_max = got_e.mx;
                    nres++;
                end
                post_done = 1'b1;
            end else if (busy) begin
                chk("hold_idx", int'(class_idx), last_idx);
                chk("hold_max", int'(max_score), last_max);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        score_valid = 1'b0;
        score       = '0;
        repeat (2) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_idx", int'(class_idx), 0);
        chk("rst_max", int'(max_score), 0);
        rst = 1'b1;

        run(basic, 0, 1'b0, 1'b0);
        run(ties, 0, 1'b0, 1'b0);
        run(allmin, 0, 1'b0, 1'b0);
        run(basic, 3, 1'b1, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            score_valid = 1'b1;
            score       = 8'sd100;
            tick();
        end
        score_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_rv", int'(result_valid), 0);
        chk("arst_idx", int'(class_idx), 0);
        chk("arst_max", int'(max_score), 0);
        tick();
        rst = 1'b1;
        run(r90, 0, 1'b0, 1'b0);

        score_valid = 1'b1;
        score       = 8'sd127;
        tick();
        tick();
        run(basic, 1, 1'b0, 1'b1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("drain", sb.size(), 0);
        repeat (3) tick();
        chk("n_results", nres, npush);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
